// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the program-counter stage: reset address,
// sequencer state encoding and redirect-select encoding.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Sequencer FSM; SLOT only exists when delay slots are enabled.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_SLOT = 1'b1
   } seq_state_e;

   // Which source supplies the next fetch address.
   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } redir_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational target calculator: branch, jump and register-jump targets,
// plus the prioritised redirect selection (jr > jump > branch > sequential).
module pc_target_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] imm_ext,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output redir_sel_e  redir_sel,
   output logic [31:0] redir_tgt,
   output logic        jr_misaligned
);

   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] jr_tgt;

   // Raw targets; the shift drops imm_ext[31:30] and all sums wrap mod 2^32.
   always_comb begin
      br_tgt        = pc_plus4 + (imm_ext << 2);
      j_tgt         = {pc_plus4[31:28], jump_index, 2'b00};
      jr_tgt        = {jr_target[31:2], 2'b00};
      jr_misaligned = (jr_target[1:0] != 2'b00);
   end

   // Priority select of the redirect source and its target.
   always_comb begin
      redir_sel = SEL_SEQ;
      redir_tgt = pc_plus4;
      if (jr) begin
         redir_sel = SEL_JR;
         redir_tgt = jr_tgt;
      end else if (jump) begin
         redir_sel = SEL_J;
         redir_tgt = j_tgt;
      end else if (branch_taken) begin
         redir_sel = SEL_BR;
         redir_tgt = br_tgt;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, the redirect flush pulse and
// the sticky JR alignment flag.
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot behaviour
// (redirect takes effect after one delay-slot fetch, no flush).
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic [31:0]       imm_ext,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic [25:0]       jump_index,
   input  logic              jr,
   input  logic [31:0]       jr_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              flush,
   output logic              align_err
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              align_err_q, align_err_d;
   redir_sel_e        redir_sel;
   logic [31:0]       redir_tgt;
   logic              jr_misaligned;

   pc_target_calc u_target_calc (
      .pc_plus4      (pc_plus4),
      .imm_ext       (imm_ext),
      .branch_taken  (branch_taken),
      .jump          (jump),
      .jump_index    (jump_index),
      .jr            (jr),
      .jr_target     (jr_target),
      .redir_sel     (redir_sel),
      .redir_tgt     (redir_tgt),
      .jr_misaligned (jr_misaligned)
   );

   // Sequential successor, wrapping past 32'hFFFF_FFFC to zero.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
   end

   assign pc        = pc_q;
   assign align_err = align_err_q;

`ifdef BRANCH_DELAY_SLOT_EN

   seq_state_e        state_q, state_d;
   logic [31:0]       pend_tgt_q, pend_tgt_d;

   // Next state: a redirect in RUN fetches the delay slot first and parks the
   // target; SLOT then loads the parked target and ignores any new request.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_tgt_d  = pend_tgt_q;
      align_err_d = align_err_q;
      if (!stall) begin
         case (state_q)
            ST_RUN: begin
               pc_d = pc_plus4;
               if (redir_sel != SEL_SEQ) begin
                  pend_tgt_d = redir_tgt;
                  state_d    = ST_SLOT;
                  if (redir_sel == SEL_JR && jr_misaligned) begin
                     align_err_d = 1'b1;
                  end
               end
            end
            ST_SLOT: begin
               pc_d    = pend_tgt_q;
               state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // State registers; reset drops any parked target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         pend_tgt_q  <= '0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_tgt_q  <= pend_tgt_d;
         align_err_q <= align_err_d;
      end
   end

   assign flush = 1'b0;

`else

   logic              flush_q, flush_d;

   // Next state: any redirect loads its target at once and arms a one-cycle
   // flush for the wrong-path instruction already fetched.
   always_comb begin
      pc_d        = pc_q;
      flush_d     = flush_q;
      align_err_d = align_err_q;
      if (!stall) begin
         if (redir_sel != SEL_SEQ) begin
            pc_d    = redir_tgt;
            flush_d = 1'b1;
         end else begin
            pc_d    = pc_plus4;
            flush_d = 1'b0;
         end
         if (redir_sel == SEL_JR && jr_misaligned) begin
            align_err_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         flush_q     <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         flush_q     <= flush_d;
         align_err_q <= align_err_d;
      end
   end

   // A held flush is masked while stalled and presented once the stall lifts.
   assign flush = flush_q & ~stall;

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a behavioural PC model. Honours BRANCH_DELAY_SLOT_EN.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [31:0] imm_ext;
   logic        branch_taken;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush;
   logic        align_err;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic        m_flush;
   logic        m_align;
   logic        m_slot;
   logic [31:0] m_pend;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .imm_ext      (imm_ext),
      .branch_taken (branch_taken),
      .jump         (jump),
      .jump_index   (jump_index),
      .jr           (jr),
      .jr_target    (jr_target),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .flush        (flush),
      .align_err    (align_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0000_3000;
      m_flush = 1'b0;
      m_align = 1'b0;
      m_slot  = 1'b0;
      m_pend  = '0;
   endtask

   // Applies one clock edge of the architectural rules to the model.
   task automatic model_step();
      logic [31:0] p4;
      logic [31:0] tgt;
      logic        req;
      if (stall) return;
      p4  = m_pc + 32'd4;
      req = 1'b1;
      tgt = p4;
      if (jr)                tgt = jr_target & 32'hFFFF_FFFC;
      else if (jump)         tgt = {p4[31:28], jump_index, 2'b00};
      else if (branch_taken) tgt = p4 + imm_ext * 32'd4;
      else                   req = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      if (m_slot) begin
         m_pc   = m_pend;
         m_slot = 1'b0;
      end else begin
         if (req) begin
            m_pend = tgt;
            m_slot = 1'b1;
            if (jr && jr_target[1:0] != 2'b00) m_align = 1'b1;
         end
         m_pc = p4;
      end
`else
      if (jr && jr_target[1:0] != 2'b00) m_align = 1'b1;
      m_pc    = req ? tgt : p4;
      m_flush = req;
`endif
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] imm,
                        input logic j, input logic [25:0] ji,
                        input logic r, input logic [31:0] rt);
      stall = s; branch_taken = b; imm_ext = imm;
      jump = j; jump_index = ji; jr = r; jr_target = rt;
   endtask

   task automatic clear();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
   endtask

   // One transaction: check outputs against the model, clock, advance model.
   task automatic cycle();
      #1;
      $display("txn stall=%0b br=%0b j=%0b jr=%0b pc=0x%08h flush=%0b align=%0b",
               stall, branch_taken, jump, jr, pc, flush, align_err);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("flush", {31'h0, flush}, {31'h0, m_flush & ~stall});
      check("align_err", {31'h0, align_err}, {31'h0, m_align});
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      clear();
      repeat (n) cycle();
   endtask

   // Asynchronous reset pulse mid-cycle; outputs must change without a clock.
   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_flush", {31'h0, flush}, 32'h0);
      check("rst_align", {31'h0, align_err}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("init_pc", pc, 32'h0000_3000);
      check("init_flush", {31'h0, flush}, 32'h0);
      check("init_align", {31'h0, align_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-run from 0x3010.
      idle(4);
      #1 check("pre_rst_pc", pc, 32'h0000_3010);
      reset_pulse();

`ifndef BRANCH_DELAY_SLOT_EN
      // Backward branch from 0x3010.
      idle(4);
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0);
      cycle();
      clear();
      #1;
      check("bwd_br_pc", pc, 32'h0000_3004);
      check("bwd_br_flush", {31'h0, flush}, 32'h1);
      cycle();
      #1;
      check("bwd_seq_pc", pc, 32'h0000_3008);
      check("bwd_seq_flush", {31'h0, flush}, 32'h0);
      reset_pulse();

      // Jump held off by a two-cycle stall.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 26'h000_0100, 1'b0, 32'h0);
      cycle();
      cycle();
      #1 check("stall_pc", pc, 32'h0000_3000);
      stall = 1'b0;
      cycle();
      clear();
      #1 check("jump_pc", pc, 32'h0000_0400);

      // Simultaneous requests: JR wins, misaligned target flagged.
      drive(1'b0, 1'b1, 32'h10, 1'b1, 26'h3, 1'b1, 32'h0000_4003);
      cycle();
      clear();
      #1;
      check("prio_pc", pc, 32'h0000_4000);
      check("prio_align", {31'h0, align_err}, 32'h1);
      repeat (10) cycle();
      #1 check("align_sticky", {31'h0, align_err}, 32'h1);

      // Sequential wrap at the top of the address space.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
      cycle();
      clear();
      cycle();
      #1 check("wrap_pc", pc, 32'h0000_0000);
      reset_pulse();

      // Large positive branch offset.
      drive(1'b0, 1'b1, 32'h0000_7FFF, 1'b0, 26'h0, 1'b0, 32'h0);
      cycle();
      clear();
      #1 check("br_far_pc", pc, 32'h0002_3000);
      reset_pulse();
`else
      // Delay slot: branch resolves after the slot fetch; branch in slot ignored.
      drive(1'b0, 1'b1, 32'h0000_0004, 1'b0, 26'h0, 1'b0, 32'h0);
      cycle();
      drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0);
      #1;
      check("slot_pc", pc, 32'h0000_3004);
      check("slot_flush", {31'h0, flush}, 32'h0);
      cycle();
      clear();
      #1;
      check("slot_tgt_pc", pc, 32'h0000_3014);
      check("slot_tgt_flush", {31'h0, flush}, 32'h0);
      cycle();
      #1 check("slot_after_pc", pc, 32'h0000_3018);
      reset_pulse();
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] imm;
         imm = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 255) - 32'd128) : $urandom;
         drive(($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0), imm,
               ($urandom_range(0, 7) == 0), 26'($urandom),
               ($urandom_range(0, 9) == 0), $urandom);
         cycle();
         if (i == 200) begin
            clear();
            reset_pulse();
         end
      end
      clear();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the 16→32 sign extender.
- Consumes the sign-extended immediate, computes branch and jump targets, and owns the PC register that drives instruction fetch.
- Produces pc / pc_plus4 for fetch and the link path, plus a flush pulse to the fetch/decode pipeline register on redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC width (fixed at 32 for this CPU; parameter kept for the bench).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall; when 1, PC and all state hold and requests are ignored.
- imm_ext  in  32  sign-extended immediate from the extender.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- jump  in  1  J/JAL request.
- jump_index  in  26  instr[25:0].
- jr  in  1  JR/JALR request.
- jr_target  in  32  register value for JR.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational, wraps mod 2^32.
- flush  out  1  one-cycle pulse; kill the wrong-path instruction.
- align_err  out  1  sticky flag: JR target had [1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, flush=0, align_err=0, pending state cleared, FSM=RUN. Release is synchronous to the next clk edge.
- Target arithmetic, all 32-bit with modular wrap:
  - br_tgt = pc_plus4 + {imm_ext[29:0],2'b00}.
  - j_tgt = {pc_plus4[31:28], jump_index, 2'b00}.
  - jr_tgt = {jr_target[31:2], 2'b00}.
- Request priority when several are asserted: jr > jump > branch_taken > sequential.
- Requests are sampled only on cycles with stall=0. During stall, pc, FSM and flush hold; flush is forced to 0.
- JR with jr_target[1:0] != 0 sets align_err. It stays set until reset; the PC still loads the aligned target.
- Without BRANCH_DELAY_SLOT_EN (single-state FSM, RUN):
  - Redirect request → pc := target on the next edge; flush=1 for exactly that following cycle.
  - No request → pc := pc_plus4, flush=0.
- Overflow at 32'hFFFF_FFFC: sequential pc wraps to 0. No error is raised.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics, using a two-state FSM (RUN, SLOT) and a 32-bit pend_tgt register.
  - RUN + request: pend_tgt := target, pc := pc_plus4 (delay-slot instruction is fetched), go to SLOT. flush is never asserted.
  - SLOT, no stall: pc := pend_tgt, go to RUN. Any request in SLOT (branch in delay slot) is ignored.
  - SLOT + stall: hold SLOT and pend_tgt.
  - Reset in SLOT discards pend_tgt.
- Undefined: behaviour as in Behaviour; flush is active.

Decomposition:
- Shared package/header cpu_pkg:
  - RESET_PC default.
  - FSM state encoding: RUN=1'b0, SLOT=1'b1.
  - Redirect-select encoding: SEQ, BR, J, JR (2 bits).
- One natural sub-module: pc_target_calc. It is purely combinational and computes br_tgt, j_tgt, jr_tgt and the selected next target from the priority rules.
- The sequencer holds the PC register, the FSM, pend_tgt and the flags.

Test Plan:
- Reset mid-run: pc=0x3010, pull rst_n low asynchronously → pc=0x0000_3000 immediately, flush=0, align_err=0.
- Backward branch, no macro: pc=0x3010, imm_ext=0xFFFF_FFFC, branch_taken=1 → next pc=0x3004, flush=1 for one cycle, then pc=0x3008.
- Jump plus stall: pc=0x3000, jump=1, jump_index=0x000_0100, stall=1 for 2 cycles → pc holds 0x3000. On stall release → pc=0x0000_0400.
- Priority and alignment: jr=1, jr_target=0x0000_4003, jump=1, branch_taken=1 at the same time → pc=0x4000, align_err=1 and it stays 1 for 10 further cycles.
- Wrap: pc=0xFFFF_FFFC, no request → pc=0x0000_0000. Branch at 0x3000 with imm_ext=0x7FFF → br_tgt=0x0002_3000.
- With BRANCH_DELAY_SLOT_EN: pc=0x3000, branch_taken=1, imm_ext=4 → pc=0x3004 (slot), then 0x3014. flush stays 0. A second branch_taken in the slot cycle is ignored.
